// File: rtl/request_unit_pkg.sv
// Shared types for the multi-core request unit: per-channel state, latched op type,
// and small decode helpers.
package request_unit_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWaitGnt = 2'b01,
    StActive  = 2'b10
  } ch_state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

  // Wide enough for TIMEOUT up to 65535.
  localparam int unsigned CntW   = 16;
  localparam int unsigned StatsW = 32;

  function automatic logic accept_req(logic ihit, logic rd, logic wr, logic halt);
    return ihit & (rd | wr) & ~halt;
  endfunction

  // Read and write together resolve to a write.
  function automatic op_e op_from_req(logic wr);
    return wr ? OpWrite : OpRead;
  endfunction

endpackage

// File: rtl/request_unit_mc_if.sv
// Per-channel request/response bundle between the cores and request_unit_mc.
// With REQUNIT_STATS_EN defined the bundle also carries stall_cnt.
interface request_unit_mc_if #(
  parameter int unsigned CHANNELS = 2
);
  import request_unit_pkg::*;

  logic [CHANNELS-1:0] MemRd;
  logic [CHANNELS-1:0] MemWr;
  logic [CHANNELS-1:0] ihit;
  logic [CHANNELS-1:0] dhit;
  logic [CHANNELS-1:0] halt;
  logic [CHANNELS-1:0] iREN;
  logic [CHANNELS-1:0] dREN;
  logic [CHANNELS-1:0] dWEN;
  logic [CHANNELS-1:0] err;

`ifdef REQUNIT_STATS_EN
  logic [CHANNELS-1:0][StatsW-1:0] stall_cnt;

  modport master (
    output MemRd, MemWr, ihit, dhit, halt,
    input  iREN, dREN, dWEN, err, stall_cnt
  );

  modport slave (
    input  MemRd, MemWr, ihit, dhit, halt,
    output iREN, dREN, dWEN, err, stall_cnt
  );
`else
  modport master (
    output MemRd, MemWr, ihit, dhit, halt,
    input  iREN, dREN, dWEN, err
  );

  modport slave (
    input  MemRd, MemWr, ihit, dhit, halt,
    output iREN, dREN, dWEN, err
  );
`endif

endinterface

// File: rtl/request_unit_mc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index
// when advance is high; pointer resets to 0.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] sel;
  logic            found;

  // Search order ptr+1, ptr+2, ..., ptr so the last winner has lowest priority.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sel = PtrW'((32'(ptr_q) + k) % N);
      if (!found && req[sel]) begin
        found = 1'b1;
        if (advance) begin
          gnt[sel] = 1'b1;
          ptr_d    = sel;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/request_unit_mc.sv
// Multi-channel request unit: one FSM per core sharing a single data port.
// Optional stall statistics are built when REQUNIT_STATS_EN is defined.
module request_unit_mc
  import request_unit_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              RST,
  request_unit_mc_if.slave  bus
);

  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] waiting;
  logic [CHANNELS-1:0] gnt;
  logic                port_free;

  // The port frees up in the same cycle the owner sees dhit, enabling back-to-back grants.
  assign port_free = ~(|active) | (|(active & bus.dhit));

  rr_arbiter #(
    .N (CHANNELS)
  ) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (waiting),
    .advance (port_free),
    .gnt     (gnt)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ch_state_e       state_q, state_d;
    op_e             op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (accept_req(bus.ihit[g], bus.MemRd[g], bus.MemWr[g], bus.halt[g])) begin
            state_d = StWaitGnt;
            op_d    = op_from_req(bus.MemWr[g]);
          end
        end
        StWaitGnt: begin
          cnt_d = '0;
          if (gnt[g]) begin
            state_d = StActive;
          end
        end
        StActive: begin
          if (bus.dhit[g]) begin
            state_d = StIdle;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= StIdle;
        op_q    <= OpRead;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        op_q    <= op_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
      end
    end

    assign active[g]  = (state_q == StActive);
    assign waiting[g] = (state_q == StWaitGnt);

    // Outputs are masked by RST so nothing is enabled while reset is held.
    assign bus.iREN[g] = ~RST & ~bus.halt[g] & (state_q == StIdle);
    assign bus.dREN[g] = ~RST & active[g] & (op_q == OpRead);
    assign bus.dWEN[g] = ~RST & active[g] & (op_q == OpWrite);
    assign bus.err[g]  = err_q;

`ifdef REQUNIT_STATS_EN
    logic [StatsW-1:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if (waiting[g] && (stall_q != {StatsW{1'b1}})) begin
        stall_d = stall_q + 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        stall_q <= '0;
      end else begin
        stall_q <= stall_d;
      end
    end

    assign bus.stall_cnt[g] = stall_q;
`endif
  end

endmodule

// File: tb/tb_request_unit_mc.sv
// Self-checking bench for request_unit_mc (CHANNELS=2, TIMEOUT=4): port-ownership
// model checked every cycle plus directed literal expectations.
module tb_request_unit_mc;

  localparam int unsigned Ch = 2;
  localparam int unsigned To = 4;

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  request_unit_mc_if #(.CHANNELS(Ch)) bus ();

  request_unit_mc #(
    .CHANNELS (Ch),
    .TIMEOUT  (To)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [Ch-1:0] act, input logic [Ch-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which channel owns the data port, who is queued, and for how long the owner has held it.
  int       m_owner;
  int       m_age;
  int       m_last;
  bit [1:0] m_wait;
  bit [1:0] m_wr;
  bit [1:0] m_err;
  bit       m_valid = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_owner = -1;
      m_age   = 0;
      m_last  = 0;
      m_wait  = '0;
      m_wr    = '0;
      m_err   = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit       freed;
      int       nowner;
      bit [1:0] old_wait;
      bit [1:0] was_idle;
      old_wait = m_wait;
      for (int i = 0; i < Ch; i++) was_idle[i] = !m_wait[i] && (m_owner != i);
      freed  = (m_owner < 0) ? 1'b1 : bus.dhit[m_owner];
      nowner = m_owner;
      if (m_owner >= 0) begin
        if (bus.dhit[m_owner]) nowner = -1;
        else if (m_age == To - 1) begin
          m_err[m_owner] = 1'b1;
          nowner = -1;
        end else m_age++;
      end
      if (freed) begin
        for (int k = 1; k <= Ch; k++) begin
          int idx;
          idx = (m_last + k) % Ch;
          if (old_wait[idx] && (nowner == m_owner || nowner < 0)) begin
            nowner       = idx;
            m_wait[idx]  = 1'b0;
            m_last       = idx;
            m_age        = 0;
            break;
          end
        end
      end
      for (int i = 0; i < Ch; i++) begin
        if (was_idle[i] && bus.ihit[i] && (bus.MemRd[i] || bus.MemWr[i]) && !bus.halt[i]) begin
          m_wait[i] = 1'b1;
          m_wr[i]   = bus.MemWr[i];
        end
      end
      m_owner = nowner;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      logic [1:0] e_iren, e_dren, e_dwen;
      for (int i = 0; i < Ch; i++) begin
        e_iren[i] = !RST && !bus.halt[i] && !m_wait[i] && (m_owner != i);
        e_dren[i] = !RST && (m_owner == i) && !m_wr[i];
        e_dwen[i] = !RST && (m_owner == i) && m_wr[i];
      end
      check("model_iREN", bus.iREN, e_iren);
      check("model_dREN", bus.dREN, e_dren);
      check("model_dWEN", bus.dWEN, e_dwen);
      check("model_err", bus.err, m_err);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [1:0] iren, input logic [1:0] dren,
                            input logic [1:0] dwen, input logic [1:0] errv);
    #1;
    check({name, "_iREN"}, bus.iREN, iren);
    check({name, "_dREN"}, bus.dREN, dren);
    check({name, "_dWEN"}, bus.dWEN, dwen);
    check({name, "_err"}, bus.err, errv);
  endtask

  task automatic drive(input logic [1:0] ih, input logic [1:0] rd, input logic [1:0] wr,
                       input logic [1:0] dh, input logic [1:0] hl);
    bus.ihit  = ih;
    bus.MemRd = rd;
    bus.MemWr = wr;
    bus.dhit  = dh;
    bus.halt  = hl;
  endtask

  logic [9:0] vec [16];

  initial begin
    RST = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    cyc();
    expect_out("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    RST = 1'b0;
    expect_out("post_reset", 2'b11, 2'b00, 2'b00, 2'b00);

    // Single read on ch0, dhit in the second active cycle.
    drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    expect_out("rd_req", 2'b11, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_out("rd_wait", 2'b10, 2'b00, 2'b00, 2'b00);
    cyc();
    expect_out("rd_act1", 2'b10, 2'b01, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    expect_out("rd_act2", 2'b10, 2'b01, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_out("rd_done", 2'b11, 2'b00, 2'b00, 2'b00);

    // Contention: last grant was ch0, so ch1 wins, then ch0 back-to-back.
    drive(2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_out("ct_wait", 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    expect_out("ct_ch1", 2'b00, 2'b10, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    expect_out("ct_ch0", 2'b10, 2'b01, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_out("ct_done", 2'b11, 2'b00, 2'b00, 2'b00);

    // Read and write together latch a write.
    drive(2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    expect_out("rw_act", 2'b10, 2'b00, 2'b01, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_out("rw_done", 2'b11, 2'b00, 2'b00, 2'b00);

    // Timeout: write on ch0 with no dhit.
    drive(2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    expect_out("to_a1", 2'b10, 2'b00, 2'b01, 2'b00);
    cyc(); cyc(); cyc();
    expect_out("to_a4", 2'b10, 2'b00, 2'b01, 2'b00);
    cyc();
    expect_out("to_err", 2'b11, 2'b00, 2'b00, 2'b01);
    cyc(); cyc();
    expect_out("to_sticky", 2'b11, 2'b00, 2'b00, 2'b01);

    // Halt while ch1 is active: request completes, new request ignored.
    drive(2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    expect_out("ht_act", 2'b01, 2'b10, 2'b00, 2'b01);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b10, 2'b10);
    expect_out("ht_act2", 2'b01, 2'b10, 2'b00, 2'b01);
    cyc(); drive(2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_out("ht_idle", 2'b01, 2'b00, 2'b00, 2'b01);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_out("ht_ignored", 2'b11, 2'b00, 2'b00, 2'b01);

    // Reset while ch0 is active.
    drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(); drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    expect_out("rs_act", 2'b10, 2'b01, 2'b00, 2'b01);
    cyc(); RST = 1'b1;
    expect_out("rs_held", 2'b00, 2'b00, 2'b00, 2'b01);
    cyc();
    expect_out("rs_edge", 2'b00, 2'b00, 2'b00, 2'b00);
    RST = 1'b0;
    expect_out("rs_release", 2'b11, 2'b00, 2'b00, 2'b00);
    cyc(); cyc();
    expect_out("rs_quiet", 2'b11, 2'b00, 2'b00, 2'b00);

    // Mixed traffic checked by the model: {ihit, MemRd, MemWr, dhit, halt}.
    vec = '{10'b11_11_00_00_00, 10'b00_00_00_00_00, 10'b00_00_00_00_00, 10'b00_00_00_10_00,
            10'b01_00_01_01_00, 10'b10_10_10_00_01, 10'b00_00_00_01_00, 10'b00_00_00_00_10,
            10'b00_00_00_10_00, 10'b11_01_10_00_00, 10'b00_00_00_00_00, 10'b00_00_00_00_00,
            10'b00_00_00_00_00, 10'b00_00_00_00_00, 10'b00_00_00_11_00, 10'b00_00_00_00_00};
    for (int v = 0; v < 16; v++) begin
      drive(vec[v][9:8], vec[v][7:6], vec[v][5:4], vec[v][3:2], vec[v][1:0]);
      cyc();
    end
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int v = 0; v < 10; v++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
